// File: rtl/prn_head_shifter_if.sv
// Print-data buffer read port, printhead serial lines and line request/status.
// master = the head shifter, slave = the buffer and controller around it.
interface prn_head_shifter_if #(
   parameter int ADDR_W = 10
);
   logic              start;
   logic [15:0]       stb_width;
   logic              rden;
   logic [ADDR_W-1:0] rdaddress;
   logic [3:0]        PrnData;
   logic [3:0]        head_dat;
   logic              head_sclk;
   logic              head_lat_n;
   logic              head_stb;
   logic              busy;
   logic              done;

   modport master (
      input  start, stb_width, PrnData,
      output rden, rdaddress, head_dat, head_sclk, head_lat_n, head_stb, busy, done
   );

   modport slave (
      output start, stb_width, PrnData,
      input  rden, rdaddress, head_dat, head_sclk, head_lat_n, head_stb, busy, done
   );
endinterface

// File: rtl/prn_head_shifter.sv
// Scans DOTS buffer words onto 4 head data lines, then latch + strobe + done (PRN_REVERSE_EN: scan DOTS-1..0).
// Line takes DOTS*(2+2*CLK_DIV)+LATCH_CYC+stb_width cycles; no backpressure, start ignored unless IDLE.
module prn_head_shifter #(
   parameter int DOTS      = 100,
   parameter int ADDR_W    = 10,
   parameter int CLK_DIV   = 4,
   parameter int LATCH_CYC = 4
) (
   input  logic                 clk,
   input  logic                 rstn,
   prn_head_shifter_if.master   bus
);

   typedef enum logic [2:0] {IDLE, FETCH, WAIT, SLO, SHI, LATCH, STROBE, DONE} state_t;

   localparam int PH_MAX = (CLK_DIV > LATCH_CYC) ? CLK_DIV : LATCH_CYC;
   localparam int PH_W   = $clog2(PH_MAX + 1);

`ifdef PRN_REVERSE_EN
   localparam logic [ADDR_W-1:0] IDX_FIRST = ADDR_W'(DOTS - 1);
   localparam logic [ADDR_W-1:0] IDX_LAST  = '0;
`else
   localparam logic [ADDR_W-1:0] IDX_FIRST = '0;
   localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(DOTS - 1);
`endif

   state_t            state;
   logic [ADDR_W-1:0] dot_idx;
   logic [ADDR_W-1:0] idx_next;
   logic [PH_W-1:0]   ph_cnt;
   logic [15:0]       stb_cnt;

`ifdef PRN_REVERSE_EN
   assign idx_next = dot_idx - ADDR_W'(1);
`else
   assign idx_next = dot_idx + ADDR_W'(1);
`endif

   // stb_cnt holds the latched strobe width until STROBE counts it down.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state          <= IDLE;
         dot_idx        <= '0;
         ph_cnt         <= '0;
         stb_cnt        <= '0;
         bus.rden       <= 1'b0;
         bus.rdaddress  <= '0;
         bus.head_dat   <= 4'h0;
         bus.head_sclk  <= 1'b0;
         bus.head_lat_n <= 1'b1;
         bus.head_stb   <= 1'b0;
         bus.busy       <= 1'b0;
         bus.done       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  stb_cnt       <= bus.stb_width;
                  dot_idx       <= IDX_FIRST;
                  bus.rdaddress <= IDX_FIRST;
                  bus.rden      <= 1'b1;
                  bus.busy      <= 1'b1;
                  state         <= FETCH;
               end
            end
            FETCH: begin
               bus.rden <= 1'b0;
               state    <= WAIT;
            end
            WAIT: begin
               bus.head_dat <= bus.PrnData;
               ph_cnt       <= PH_W'(CLK_DIV);
               state        <= SLO;
            end
            SLO: begin
               if (ph_cnt == PH_W'(1)) begin
                  ph_cnt        <= PH_W'(CLK_DIV);
                  bus.head_sclk <= 1'b1;
                  state         <= SHI;
               end else begin
                  ph_cnt <= ph_cnt - PH_W'(1);
               end
            end
            SHI: begin
               if (ph_cnt == PH_W'(1)) begin
                  bus.head_sclk <= 1'b0;
                  if (dot_idx == IDX_LAST) begin
                     bus.head_lat_n <= 1'b0;
                     ph_cnt         <= PH_W'(LATCH_CYC);
                     state          <= LATCH;
                  end else begin
                     dot_idx       <= idx_next;
                     bus.rdaddress <= idx_next;
                     bus.rden      <= 1'b1;
                     state         <= FETCH;
                  end
               end else begin
                  ph_cnt <= ph_cnt - PH_W'(1);
               end
            end
            LATCH: begin
               if (ph_cnt == PH_W'(1)) begin
                  bus.head_lat_n <= 1'b1;
                  if (stb_cnt == 16'd0) begin
                     bus.done <= 1'b1;
                     bus.busy <= 1'b0;
                     state    <= DONE;
                  end else begin
                     bus.head_stb <= 1'b1;
                     state        <= STROBE;
                  end
               end else begin
                  ph_cnt <= ph_cnt - PH_W'(1);
               end
            end
            STROBE: begin
               if (stb_cnt == 16'd1) begin
                  bus.head_stb <= 1'b0;
                  bus.done     <= 1'b1;
                  bus.busy     <= 1'b0;
                  state        <= DONE;
               end else begin
                  stb_cnt <= stb_cnt - 16'd1;
               end
            end
            DONE: begin
               bus.done <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_prn_head_shifter.sv
// Randomized line-level bench: buffer model plus timing/data reference derived from the line rules.
module tb_prn_head_shifter;
   localparam int DOTS      = 100;
   localparam int ADDR_W    = 10;
   localparam int CLK_DIV   = 4;
   localparam int LATCH_CYC = 4;
   localparam int DOT_CYC   = 2 + 2 * CLK_DIV;

   logic clk = 1'b0;
   logic rstn;
   int   n_chk = 0;
   int   n_err = 0;
   logic [3:0] mem [0:1023];

   prn_head_shifter_if #(.ADDR_W(ADDR_W)) bus ();

   prn_head_shifter #(
      .DOTS(DOTS), .ADDR_W(ADDR_W), .CLK_DIV(CLK_DIV), .LATCH_CYC(LATCH_CYC)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Buffer: data appears the cycle after the read enable.
   always @(posedge clk) begin
      if (bus.rden) bus.PrnData <= mem[bus.rdaddress];
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic int exp_addr(input int k);
`ifdef PRN_REVERSE_EN
      return DOTS - 1 - k;
`else
      return k;
`endif
   endfunction

   task automatic chk_reset_outputs(input string pfx);
      chk({pfx, "_rden"},   int'(bus.rden), 0);
      chk({pfx, "_rdaddr"}, int'(bus.rdaddress), 0);
      chk({pfx, "_dat"},    int'(bus.head_dat), 0);
      chk({pfx, "_sclk"},   int'(bus.head_sclk), 0);
      chk({pfx, "_lat_n"},  int'(bus.head_lat_n), 1);
      chk({pfx, "_stb"},    int'(bus.head_stb), 0);
      chk({pfx, "_busy"},   int'(bus.busy), 0);
      chk({pfx, "_done"},   int'(bus.done), 0);
   endtask

   // Runs one line and checks it; t=0 is the first cycle after the accepted start.
   task automatic run_line(input int width, input bit extra, input bit pre,
                           input bit chain, input int next_w);
      int n_exp;
      int addr_q[$];
      int dat_q[$];
      int rise_t[$];
      int busy_c, hi_c, lat_c, lat_first, lat_last, stb_c, stb_first, stb_last, done_t;
      bit prev_sclk, seen_done;
      n_exp = DOTS * DOT_CYC + LATCH_CYC + width;
      busy_c = 0; hi_c = 0; lat_c = 0; lat_first = -1; lat_last = -1;
      stb_c = 0; stb_first = -1; stb_last = -1; done_t = -1;
      prev_sclk = 1'b0; seen_done = 1'b0;
      if (!pre) begin
         bus.stb_width = 16'(width);
         bus.start = 1'b1;
         @(negedge clk);
         bus.start = 1'b0;
      end
      for (int t = 0; t < n_exp + 50 && !seen_done; t++) begin
         if (bus.rden) addr_q.push_back(int'(bus.rdaddress));
         if (bus.head_sclk && !prev_sclk) begin
            dat_q.push_back(int'(bus.head_dat));
            rise_t.push_back(t);
         end
         if (bus.head_sclk) hi_c++;
         prev_sclk = bus.head_sclk;
         if (!bus.head_lat_n) begin
            if (lat_first < 0) lat_first = t;
            lat_last = t;
            lat_c++;
         end
         if (bus.head_stb) begin
            if (stb_first < 0) stb_first = t;
            stb_last = t;
            stb_c++;
         end
         if (bus.busy) busy_c++;
         if (bus.done) begin
            done_t = t;
            seen_done = 1'b1;
         end
         if (!seen_done) begin
            bus.start = extra && (t == 5 || t == 500);
            bus.stb_width = 16'($urandom);
            @(negedge clk);
         end
      end
      if (!seen_done) begin
         chk("line_timeout", 0, 1);
         bus.start = 1'b0;
      end else begin
         bus.start = extra;
         if (chain) bus.stb_width = 16'(next_w);
         @(negedge clk);
         chk("done_single", int'(bus.done), 0);
         chk("idle_after_done", int'(bus.busy), 0);
         bus.start = chain;
         @(negedge clk);
         bus.start = 1'b0;
         chk("second_start", int'(bus.busy), chain ? 1 : 0);
      end
      chk("done_t", done_t, n_exp);
      chk("busy_cyc", busy_c, n_exp);
      chk("sclk_edges", dat_q.size(), DOTS);
      chk("rd_cnt", addr_q.size(), DOTS);
      chk("sclk_hi_cyc", hi_c, DOTS * CLK_DIV);
      for (int k = 0; k < DOTS; k++) begin
         if (k < addr_q.size()) chk($sformatf("rdaddr[%0d]", k), addr_q[k], exp_addr(k));
         if (k < dat_q.size()) begin
            chk($sformatf("dat[%0d]", k), dat_q[k], int'(mem[exp_addr(k)]));
            chk($sformatf("rise_t[%0d]", k), rise_t[k], k * DOT_CYC + 2 + CLK_DIV);
         end
      end
      chk("lat_first", lat_first, DOTS * DOT_CYC);
      chk("lat_cyc", lat_c, LATCH_CYC);
      chk("lat_span", lat_last - lat_first + 1, LATCH_CYC);
      chk("stb_cyc", stb_c, width);
      if (width > 0) begin
         chk("stb_first", stb_first, lat_last + 1);
         chk("stb_span", stb_last - stb_first + 1, width);
         chk("done_after_stb", done_t, stb_last + 1);
      end else begin
         chk("done_after_lat", done_t, lat_last + 1);
      end
   endtask

   task automatic reset_midline();
      int rises, act;
      bit prev;
      rises = 0; act = 0; prev = 1'b0;
      bus.stb_width = 16'd5;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int t = 0; t < 2000 && rises < 38; t++) begin
         if (bus.head_sclk && !prev) rises++;
         prev = bus.head_sclk;
         if (rises < 38) @(negedge clk);
      end
      chk("rst_reach_dot37", rises, 38);
      chk("rst_in_shi", int'(bus.head_sclk), 1);
      rstn = 1'b0;
      #1;
      chk_reset_outputs("rst_mid");
      @(negedge clk);
      rstn = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (bus.rden || bus.head_sclk || bus.busy || bus.done || bus.head_stb || !bus.head_lat_n)
            act++;
      end
      chk("rst_quiet", act, 0);
   endtask

   initial begin
      int w2;
      rstn = 1'b0;
      bus.start = 1'b0;
      bus.stb_width = 16'd0;
      bus.PrnData = 4'h0;
      repeat (3) @(negedge clk);
      chk_reset_outputs("por");
      rstn = 1'b1;
      repeat (3) @(negedge clk);
      chk("por_idle_busy", int'(bus.busy), 0);

      for (int k = 0; k < 1024; k++) mem[k] = 4'(k);
      run_line(10, 1'b0, 1'b0, 1'b0, 0);
      run_line(0, 1'b0, 1'b0, 1'b0, 0);

      for (int k = 0; k < 1024; k++) mem[k] = 4'($urandom);
      w2 = $urandom_range(0, 20);
      run_line(10, 1'b1, 1'b0, 1'b1, w2);
      run_line(w2, 1'b0, 1'b1, 1'b0, 0);

      for (int k = 0; k < 1024; k++) mem[k] = 4'(k);
      reset_midline();

      for (int k = 0; k < 1024; k++) mem[k] = 4'($urandom);
      run_line($urandom_range(1, 30), 1'b1, 1'b0, 1'b0, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
